// File: rtl/conv_csr_mc.sv
// conv_csr_mc: ICB register window that starts N_CH conv channels, tracks busy/done
// per channel and counts busy cycles per channel.
// Optional feature macro: CONV_CSR_IRQ_EN adds the IE register and the irq output.
//   With CONV_CSR_IRQ_EN undefined, there is no irq port and any IE access returns an error.
// Register map (word offsets from BASE_ADDR, addr[1:0] ignored):
//   0x00 CTRL   write-1 start bits; reads 0
//   0x04 STAT   busy[N_CH-1:0] RO, done[8+N_CH-1:8] sticky W1C
//   0x08 IE     irq enable (CONV_CSR_IRQ_EN only)
//   0x10+4*i    CYC_i, RO, zero-extended
module conv_csr_mc #(
   parameter logic [31:0] BASE_ADDR = 32'h1004_0000,
   parameter int unsigned N_CH      = 4,
   parameter int unsigned CNT_W     = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              csr_icb_cmd_valid,
   output logic              csr_icb_cmd_ready,
   input  logic [31:0]       csr_icb_cmd_addr,
   input  logic              csr_icb_cmd_read,
   input  logic [31:0]       csr_icb_cmd_wdata,
   input  logic [3:0]        csr_icb_cmd_wmask,
   output logic              csr_icb_rsp_valid,
   input  logic              csr_icb_rsp_ready,
   output logic [31:0]       csr_icb_rsp_rdata,
   output logic              csr_icb_rsp_err,
   output logic [N_CH-1:0]   ch_start,
   input  logic [N_CH-1:0]   ch_done
`ifdef CONV_CSR_IRQ_EN
   ,
   output logic              irq
`endif
);

   localparam logic [29:0]      WORD_CTRL = 30'd0;
   localparam logic [29:0]      WORD_STAT = 30'd1;
   localparam logic [29:0]      WORD_IE   = 30'd2;
   localparam logic [29:0]      WORD_CYC0 = 30'd4;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   logic [N_CH-1:0]  r_busy;
   logic [N_CH-1:0]  r_done;
   logic [N_CH-1:0]  r_ch_start;
   logic [CNT_W-1:0] r_cyc [N_CH];
   logic             r_rsp_valid;
   logic [31:0]      r_rsp_rdata;
   logic             r_rsp_err;

   logic             w_hs;
   logic [31:0]      w_off;
   logic [29:0]      w_word;
   logic             w_hit_ctrl;
   logic             w_hit_stat;
   logic             w_hit_ie;
   logic             w_hit_cyc;
   logic [31:0]      w_cyc_rd;
   logic [31:0]      w_stat;
   logic             w_err;
   logic [31:0]      w_rdata;
   logic             w_wr_ok;
   logic [N_CH-1:0]  w_start;
   logic [N_CH-1:0]  w_done_clr;
   logic             w_unused_ok;

`ifdef CONV_CSR_IRQ_EN
   logic [N_CH-1:0]  r_ie;
   logic             r_irq;
   logic             w_ie_wr;
`endif

   // One outstanding transaction: a new command is taken only when the response slot frees up
   assign csr_icb_cmd_ready = ~r_rsp_valid | csr_icb_rsp_ready;
   assign w_hs              = csr_icb_cmd_valid & csr_icb_cmd_ready;

   // Byte offset bits, unused wdata/wmask lanes
   assign w_unused_ok = ^{csr_icb_cmd_wdata, csr_icb_cmd_wmask, w_off[1:0]};

   // Address decode, read mux and write-side effects of the current command
   always_comb begin
      w_off      = csr_icb_cmd_addr - BASE_ADDR;
      w_word     = w_off[31:2];
      w_hit_ctrl = (w_word == WORD_CTRL);
      w_hit_stat = (w_word == WORD_STAT);
`ifdef CONV_CSR_IRQ_EN
      w_hit_ie   = (w_word == WORD_IE);
`else
      w_hit_ie   = 1'b0;
`endif
      w_hit_cyc  = 1'b0;
      w_cyc_rd   = '0;
      for (int i = 0; i < int'(N_CH); i++) begin
         if (w_word == WORD_CYC0 + 30'(i)) begin
            w_hit_cyc = 1'b1;
            w_cyc_rd  = 32'(r_cyc[i]);
         end
      end

      // CYC_i is read-only, so a write to it is an error like an unmapped address
      w_err = ~(w_hit_ctrl | w_hit_stat | w_hit_ie | w_hit_cyc) |
              (w_hit_cyc & ~csr_icb_cmd_read);

      w_stat             = '0;
      w_stat[N_CH-1:0]   = r_busy;
      w_stat[8 +: N_CH]  = r_done;

      w_rdata = '0;
      if (!w_err && csr_icb_cmd_read) begin
         if (w_hit_stat) w_rdata = w_stat;
         if (w_hit_cyc)  w_rdata = w_cyc_rd;
`ifdef CONV_CSR_IRQ_EN
         if (w_hit_ie)   w_rdata = 32'(r_ie);
`endif
      end

      w_wr_ok    = w_hs & ~csr_icb_cmd_read & ~w_err;
      // Start requests to busy channels are dropped silently
      w_start    = (w_wr_ok & w_hit_ctrl & csr_icb_cmd_wmask[0]) ?
                   (csr_icb_cmd_wdata[N_CH-1:0] & ~r_busy) : '0;
      w_done_clr = (w_wr_ok & w_hit_stat & csr_icb_cmd_wmask[1]) ?
                   csr_icb_cmd_wdata[8 +: N_CH] : '0;
`ifdef CONV_CSR_IRQ_EN
      w_ie_wr    = w_wr_ok & w_hit_ie & csr_icb_cmd_wmask[0];
`endif
   end

   // Response register: loaded on handshake, held until the host takes it
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else if (w_hs) begin
         r_rsp_valid <= 1'b1;
         r_rsp_rdata <= w_rdata;
         r_rsp_err   <= w_err;
      end else if (csr_icb_rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end

   // Channel status: start pulse, busy, sticky done (a coincident ch_done beats the clear)
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ch_start <= '0;
         r_busy     <= '0;
         r_done     <= '0;
      end else begin
         r_ch_start <= w_start;
         r_busy     <= (r_busy & ~ch_done) | w_start;
         r_done     <= (r_done & ~w_done_clr) | ch_done;
      end
   end

   // Busy-cycle counters: cleared with the start pulse, counting stops on the done cycle
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(N_CH); i++) begin
         if (rst) begin
            r_cyc[i] <= '0;
         end else if (w_start[i]) begin
            r_cyc[i] <= '0;
         end else if (r_busy[i] && !ch_done[i] && (r_cyc[i] != CNT_MAX)) begin
            r_cyc[i] <= r_cyc[i] + CNT_W'(1);
         end
      end
   end

`ifdef CONV_CSR_IRQ_EN
   // Interrupt enable register and registered level interrupt
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ie  <= '0;
         r_irq <= 1'b0;
      end else begin
         if (w_ie_wr) r_ie <= csr_icb_cmd_wdata[N_CH-1:0];
         r_irq <= |(r_done & r_ie);
      end
   end

   assign irq = r_irq;
`endif

   assign csr_icb_rsp_valid = r_rsp_valid;
   assign csr_icb_rsp_rdata = r_rsp_rdata;
   assign csr_icb_rsp_err   = r_rsp_err;
   assign ch_start          = r_ch_start;

endmodule

// File: tb/tb_conv_csr_mc.sv
// Self-checking bench for conv_csr_mc: a register-level reference model compared every
// cycle, plus directed transactions with hand-computed expectations.
// Builds with or without CONV_CSR_IRQ_EN.
`timescale 1ns/1ps
module tb_conv_csr_mc;

   localparam logic [31:0] BASE  = 32'h1004_0000;
   localparam int          N_CH  = 4;
   localparam int          CNT_W = 8;
   localparam int unsigned CMAX  = 255;
`ifdef CONV_CSR_IRQ_EN
   localparam bit IRQ_ON = 1'b1;
`else
   localparam bit IRQ_ON = 1'b0;
`endif

   logic            clk;
   logic            rst;
   logic            cmd_valid;
   logic            cmd_ready;
   logic [31:0]     cmd_addr;
   logic            cmd_read;
   logic [31:0]     cmd_wdata;
   logic [3:0]      cmd_wmask;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [31:0]     rsp_rdata;
   logic            rsp_err;
   logic [N_CH-1:0] ch_start;
   logic [N_CH-1:0] ch_done;
`ifdef CONV_CSR_IRQ_EN
   logic            irq;
`endif

   conv_csr_mc #(.BASE_ADDR(BASE), .N_CH(N_CH), .CNT_W(CNT_W)) dut (
      .clk               (clk),
      .rst               (rst),
      .csr_icb_cmd_valid (cmd_valid),
      .csr_icb_cmd_ready (cmd_ready),
      .csr_icb_cmd_addr  (cmd_addr),
      .csr_icb_cmd_read  (cmd_read),
      .csr_icb_cmd_wdata (cmd_wdata),
      .csr_icb_cmd_wmask (cmd_wmask),
      .csr_icb_rsp_valid (rsp_valid),
      .csr_icb_rsp_ready (rsp_ready),
      .csr_icb_rsp_rdata (rsp_rdata),
      .csr_icb_rsp_err   (rsp_err),
      .ch_start          (ch_start),
      .ch_done           (ch_done)
`ifdef CONV_CSR_IRQ_EN
      ,
      .irq               (irq)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc_no   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc_no <= cyc_no + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model (register-level view of the block) ----------------
   bit              m_live;
   bit [N_CH-1:0]   m_busy, m_done, m_ie, m_start;
   int unsigned     m_cyc [N_CH];
   bit              m_rsp_valid, m_rsp_err;
   bit [31:0]       m_rsp_rdata;
`ifdef CONV_CSR_IRQ_EN
   bit              m_irq;
`endif

   always @(posedge clk) begin : model_p
      bit            hs;
      int            kind;
      int            idx;
      int            w;
      logic [31:0]   off;
      bit [N_CH-1:0] st, clr, nb, nd;
      bit [31:0]     rd;
      bit            er;
      if (rst) begin
         m_live      <= 1'b1;
         m_busy      <= '0;
         m_done      <= '0;
         m_ie        <= '0;
         m_start     <= '0;
         m_rsp_valid <= 1'b0;
         m_rsp_err   <= 1'b0;
         m_rsp_rdata <= '0;
         for (int i = 0; i < N_CH; i++) m_cyc[i] <= 0;
`ifdef CONV_CSR_IRQ_EN
         m_irq       <= 1'b0;
`endif
      end else begin
         hs   = cmd_valid && (!m_rsp_valid || rsp_ready);
         off  = cmd_addr - BASE;
         w    = int'(off[31:2]);
         kind = -1;
         idx  = 0;
         if (w == 0)                      kind = 0;
         else if (w == 1)                 kind = 1;
         else if (w == 2 && IRQ_ON)       kind = 2;
         else if (w >= 4 && w < 4 + N_CH) begin kind = 3; idx = w - 4; end
         if (kind == 3 && !cmd_read) kind = -1;
         st = '0; clr = '0; rd = '0; er = 1'b0;
         if (hs) begin
            if (kind < 0) er = 1'b1;
            else if (cmd_read) begin
               if (kind == 1) for (int i = 0; i < N_CH; i++) begin
                  rd[i] = m_busy[i]; rd[8+i] = m_done[i];
               end
               if (kind == 2) for (int i = 0; i < N_CH; i++) rd[i] = m_ie[i];
               if (kind == 3) rd = 32'(m_cyc[idx]);
            end else begin
               if (kind == 0 && cmd_wmask[0])
                  for (int i = 0; i < N_CH; i++) st[i] = cmd_wdata[i] && !m_busy[i];
               if (kind == 1 && cmd_wmask[1])
                  for (int i = 0; i < N_CH; i++) clr[i] = cmd_wdata[8+i];
               if (kind == 2 && cmd_wmask[0]) m_ie <= cmd_wdata[N_CH-1:0];
            end
            m_rsp_valid <= 1'b1;
            m_rsp_rdata <= rd;
            m_rsp_err   <= er;
         end else if (rsp_ready) begin
            m_rsp_valid <= 1'b0;
         end
         for (int i = 0; i < N_CH; i++) begin
            nb[i] = st[i] || (m_busy[i] && !ch_done[i]);
            nd[i] = ch_done[i] || (m_done[i] && !clr[i]);
            if (st[i]) m_cyc[i] <= 0;
            else if (m_busy[i] && !ch_done[i] && m_cyc[i] < CMAX) m_cyc[i] <= m_cyc[i] + 1;
         end
         m_busy  <= nb;
         m_done  <= nd;
         m_start <= st;
`ifdef CONV_CSR_IRQ_EN
         m_irq   <= |(m_done & m_ie);
`endif
      end
   end

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      #1;
      if (m_live) begin
         chk("cmd_ready", 32'(cmd_ready), 32'(!m_rsp_valid || rsp_ready));
         chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
         if (m_rsp_valid) begin
            chk("rsp_rdata", rsp_rdata, m_rsp_rdata);
            chk("rsp_err", 32'(rsp_err), 32'(m_rsp_err));
         end
         chk("ch_start", 32'(ch_start), 32'(m_start));
`ifdef CONV_CSR_IRQ_EN
         chk("irq", 32'(irq), 32'(m_irq));
`endif
      end
   end

   // ---------------- host-side tasks ----------------
   task automatic tick;
      @(negedge clk);
      #2;
   endtask

   task automatic icb(input logic [31:0] a, input logic rdn, input logic [31:0] wd,
                      input logic [3:0] wm, input logic [N_CH-1:0] dp,
                      output logic [31:0] rdata, output logic err);
      int g;
      cmd_valid = 1'b1; cmd_addr = a; cmd_read = rdn;
      cmd_wdata = wd; cmd_wmask = wm; ch_done = dp; rsp_ready = 1'b1;
      g = 0;
      while (!cmd_ready && g < 20) begin tick; g++; end
      if (g == 20) chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      tick;
      cmd_valid = 1'b0;
      ch_done   = '0;
      if (rsp_valid !== 1'b1) chk("rsp_after_hs", 32'(rsp_valid), 32'd1);
      rdata = rsp_rdata;
      err   = rsp_err;
   endtask

   task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] ed, input logic ee);
      logic [31:0] d;
      logic        e;
      icb(a, 1'b1, 32'h0, 4'h0, '0, d, e);
      chk({nm, "_data"}, d, ed);
      chk({nm, "_err"}, 32'(e), 32'(ee));
   endtask

   task automatic wr_chk(input string nm, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] wm, input logic [N_CH-1:0] dp, input logic ee);
      logic [31:0] d;
      logic        e;
      icb(a, 1'b0, wd, wm, dp, d, e);
      chk({nm, "_data"}, d, 32'h0);
      chk({nm, "_err"}, 32'(e), 32'(ee));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   // ---------------- directed scenario ----------------
   initial begin
      int c0;
      rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_read = 1'b0;
      cmd_wdata = '0; cmd_wmask = '0; rsp_ready = 1'b1; ch_done = '0;
      repeat (3) tick;
      rst = 1'b0;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_ch_start", 32'(ch_start), 32'd0);
`ifdef CONV_CSR_IRQ_EN
      chk("rst_irq", 32'(irq), 32'd0);
`endif
      tick;
      rd_chk("rst_stat", BASE + 32'h4, 32'h0, 1'b0);
      rd_chk("rst_cyc0", BASE + 32'h10, 32'h0, 1'b0);

      // start ch0, done 10 cycles after the start pulse
      wr_chk("start0", BASE, 32'h1, 4'hF, '0, 1'b0);
      chk("start0_pulse", 32'(ch_start), 32'h1);
      c0 = cyc_no;
      tick;
      chk("start0_single", 32'(ch_start), 32'h0);
      rd_chk("stat_busy0", BASE + 32'h4, 32'h1, 1'b0);
      while (cyc_no < c0 + 10) tick;
      ch_done = 4'b0001;
      tick;
      ch_done = '0;
      rd_chk("stat_done0", BASE + 32'h4, 32'h100, 1'b0);
      rd_chk("cyc0_10", BASE + 32'h10, 32'd10, 1'b0);
      wr_chk("clr_lane0", BASE + 32'h4, 32'h100, 4'b0001, '0, 1'b0);
      rd_chk("stat_lane_kept", BASE + 32'h4, 32'h100, 1'b0);
      wr_chk("clr_done0", BASE + 32'h4, 32'h100, 4'b0010, '0, 1'b0);
      rd_chk("stat_cleared", BASE + 32'h4, 32'h0, 1'b0);

      // start to a busy channel is ignored without error
      wr_chk("start0b", BASE, 32'h1, 4'hF, '0, 1'b0);
      chk("start0b_pulse", 32'(ch_start), 32'h1);
      wr_chk("start0_busy", BASE, 32'h1, 4'hF, '0, 1'b0);
      chk("busy_no_pulse", 32'(ch_start), 32'h0);
      ch_done = 4'b0001; tick; ch_done = '0;
      ch_done = 4'b1000; tick; ch_done = '0;
      rd_chk("stat_idle_done", BASE + 32'h4, 32'h900, 1'b0);
      wr_chk("clr_all", BASE + 32'h4, 32'hF00, 4'b0010, '0, 1'b0);

      // done-clear colliding with ch_done[1]: the set wins
      ch_done = 4'b0010; tick; ch_done = '0;
      rd_chk("stat_done1", BASE + 32'h4, 32'h200, 1'b0);
      wr_chk("clr_collide", BASE + 32'h4, 32'h200, 4'b0010, 4'b0010, 1'b0);
      rd_chk("stat_collide", BASE + 32'h4, 32'h200, 1'b0);
      wr_chk("clr_done1", BASE + 32'h4, 32'h200, 4'b0010, '0, 1'b0);
      rd_chk("stat_clr1", BASE + 32'h4, 32'h0, 1'b0);

      // CTRL without byte lane 0 does nothing; CTRL reads zero
      wr_chk("ctrl_nolane", BASE, 32'hF, 4'b1110, '0, 1'b0);
      chk("nolane_no_pulse", 32'(ch_start), 32'h0);
      rd_chk("ctrl_read", BASE, 32'h0, 1'b0);

      // multi-channel start and counter saturation
      wr_chk("start_c0", BASE, 32'h1, 4'hF, '0, 1'b0);
      wr_chk("start_all", BASE, 32'hF, 4'hF, '0, 1'b0);
      chk("multi_pulse", 32'(ch_start), 32'hE);
      rd_chk("stat_all_busy", BASE + 32'h4, 32'hF, 1'b0);
      repeat (300) tick;
      rd_chk("cyc2_sat", BASE + 32'h18, 32'd255, 1'b0);
      ch_done = 4'hF; tick; ch_done = '0;
      repeat (3) tick;
      rd_chk("cyc2_hold", BASE + 32'h18, 32'd255, 1'b0);
      rd_chk("cyc0_addr_lsb", BASE + 32'h13, 32'd255, 1'b0);
      rd_chk("stat_all_done", BASE + 32'h4, 32'hF00, 1'b0);
      wr_chk("clr_all2", BASE + 32'h4, 32'hF00, 4'b0010, '0, 1'b0);

      // error responses
      rd_chk("err_0c", BASE + 32'hC, 32'h0, 1'b1);
      wr_chk("err_wr_cyc", BASE + 32'h10, 32'hFFFF, 4'hF, '0, 1'b1);
      rd_chk("cyc0_unchanged", BASE + 32'h10, 32'd255, 1'b0);
      rd_chk("err_cyc4", BASE + 32'h20, 32'h0, 1'b1);
      rd_chk("err_below", BASE - 32'h4, 32'h0, 1'b1);
`ifdef CONV_CSR_IRQ_EN
      wr_chk("ie_wr", BASE + 32'h8, 32'h2, 4'b0001, '0, 1'b0);
      rd_chk("ie_rd", BASE + 32'h8, 32'h2, 1'b0);
      // irq follows done&IE one registered cycle later
      ch_done = 4'b0010; tick; ch_done = '0;
      chk("irq_lag", 32'(irq), 32'd0);
      tick;
      chk("irq_set", 32'(irq), 32'd1);
      wr_chk("clr_irq", BASE + 32'h4, 32'h200, 4'b0010, '0, 1'b0);
      tick;
      tick;
      chk("irq_clr", 32'(irq), 32'd0);
`else
      rd_chk("err_ie_rd", BASE + 32'h8, 32'h0, 1'b1);
      wr_chk("err_ie_wr", BASE + 32'h8, 32'h2, 4'hF, '0, 1'b1);
`endif
      rd_chk("stat_pre_bp", BASE + 32'h4, 32'h0, 1'b0);

      // back-pressure: response held 3 cycles, a pending CTRL write waits
      cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = BASE + 32'h4; rsp_ready = 1'b0;
      tick;
      cmd_read = 1'b0; cmd_addr = BASE; cmd_wdata = 32'h1; cmd_wmask = 4'hF;
      for (int k = 0; k < 3; k++) begin
         chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
         chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_rdata", rsp_rdata, 32'h0);
         chk("bp_err", 32'(rsp_err), 32'd0);
         chk("bp_no_start", 32'(ch_start), 32'h0);
         tick;
      end
      rsp_ready = 1'b1;
      tick;
      cmd_valid = 1'b0;
      chk("bp_pending_start", 32'(ch_start), 32'h1);
      chk("bp_wr_rsp", 32'(rsp_valid), 32'd1);
      tick;
      chk("bp_rsp_drained", 32'(rsp_valid), 32'd0);
      ch_done = 4'b0001; tick; ch_done = '0;
      wr_chk("clr_bp", BASE + 32'h4, 32'h100, 4'b0010, '0, 1'b0);

      // reset mid-transaction drops the response and ignores ch_done
      wr_chk("start2", BASE, 32'h4, 4'hF, '0, 1'b0);
      chk("start2_pulse", 32'(ch_start), 32'h4);
      cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = BASE + 32'h4; rsp_ready = 1'b0;
      tick;
      cmd_valid = 1'b0; rst = 1'b1; ch_done = 4'b0100;
      tick;
      rst = 1'b0; ch_done = '0; rsp_ready = 1'b1;
      chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
      rd_chk("rst_mid_stat", BASE + 32'h4, 32'h0, 1'b0);
      rd_chk("rst_mid_cyc2", BASE + 32'h18, 32'h0, 1'b0);
      tick;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
